// File: rtl/pipelined_addsub_if.sv
// ============================================================================
// Module   : pipelined_addsub_if
// Brief    : Operand/result handshake bundle for the pipelined add/subtract.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_addsub_if #(
  parameter int B = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] a;
  logic [B-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/pipelined_addsub.sv
// ============================================================================
// Module   : pipelined_addsub
// Brief    : B-bit add/subtract split into STAGES chunks, one chunk per stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_addsub #(
  parameter int B      = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  bus
);

  localparam int             C_W    = B / STAGES;
  localparam int             C_L    = STAGES - 1;
  localparam int             C_NMID = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [B-1:0]   C_MASK = B'({C_W{1'b1}});

  logic         w_adv;
  logic [B-1:0] w_bb0;
  logic         w_c0;
  logic         w_ovf;

  // Per-stage input view: stage 0 sees the ports, stage k sees stage k-1 regs
  logic         w_v_in   [STAGES];
  logic [B-1:0] w_a_in   [STAGES];
  logic [B-1:0] w_bb_in  [STAGES];
  logic [B-1:0] w_sum_in [STAGES];
  logic         w_c_in   [STAGES];
  logic [C_W:0] w_res    [STAGES];
  logic [B-1:0] w_sum_out[STAGES];

  logic         r_v   [C_NMID];
  logic [B-1:0] r_a   [C_NMID];
  logic [B-1:0] r_bb  [C_NMID];
  logic [B-1:0] r_sum [C_NMID];
  logic         r_c   [C_NMID];

  logic         r_out_valid;
  logic [B-1:0] r_s;
  logic         r_cout;
  logic         r_ovf;

  assign w_adv = !r_out_valid || bus.out_ready;
  assign w_bb0 = bus.sub ? ~bus.b : bus.b;
  assign w_c0  = bus.sub ? 1'b1 : bus.cin;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_v_in[k]   = bus.in_valid;
        assign w_a_in[k]   = bus.a;
        assign w_bb_in[k]  = w_bb0;
        assign w_sum_in[k] = '0;
        assign w_c_in[k]   = w_c0;
      end else begin : g_next
        assign w_v_in[k]   = r_v[k-1];
        assign w_a_in[k]   = r_a[k-1];
        assign w_bb_in[k]  = r_bb[k-1];
        assign w_sum_in[k] = r_sum[k-1];
        assign w_c_in[k]   = r_c[k-1];
      end

      assign w_res[k] = {1'b0, w_a_in[k][k*C_W +: C_W]}
                      + {1'b0, w_bb_in[k][k*C_W +: C_W]}
                      + {{C_W{1'b0}}, w_c_in[k]};

      // Splice this stage's chunk into the partial sum; lower chunks pass through
      assign w_sum_out[k] = (w_sum_in[k] & ~(C_MASK << (k*C_W)))
                          | (B'(w_res[k][C_W-1:0]) << (k*C_W));
    end
  endgenerate

  assign w_ovf = (w_a_in[C_L][B-1] == w_bb_in[C_L][B-1])
              && (w_sum_out[C_L][B-1] != w_a_in[C_L][B-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_NMID; i++) begin
        r_v[i]   <= 1'b0;
        r_a[i]   <= '0;
        r_bb[i]  <= '0;
        r_sum[i] <= '0;
        r_c[i]   <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        r_v[i]   <= w_v_in[i];
        r_a[i]   <= w_a_in[i];
        r_bb[i]  <= w_bb_in[i];
        r_sum[i] <= w_sum_out[i];
        r_c[i]   <= w_res[i][C_W];
      end
      r_out_valid <= w_v_in[C_L];
      r_s         <= w_sum_out[C_L];
      r_cout      <= w_res[C_L][C_W];
      r_ovf       <= w_ovf;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = (r_s == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Directed and randomised self-checking bench for pipelined_addsub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.B(32)) bus ();
  pipelined_addsub #(.B(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  pipelined_addsub_if #(.B(8)) sw1 ();
  pipelined_addsub #(.B(8), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .bus(sw1.slave));

  pipelined_addsub_if #(.B(8)) sw8 ();
  pipelined_addsub #(.B(8), .STAGES(8)) u_s8 (.clk(clk), .rst(rst), .bus(sw8.slave));

  // Independent full-width reference: {s, cout, ovf, zero}
  function automatic logic [10:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] t;
    logic       v;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
    v  = (a[7] == bb[7]) && (t[7] != a[7]);
    return {t[7:0], t[8], v, (t[7:0] == 8'd0)};
  endfunction

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got v=%b s=%h c=%b o=%b z=%b want v=0 s=0 c=0 o=0 z=1",
               bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero);
    end
    total++;
    if ({sw1.out_valid, sw8.out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_sweep_valid: got %b want 00", {sw1.out_valid, sw8.out_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    send_one(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_out(lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL ripple_latency: got %0d want 4", lat);
    end
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ripple_result: got s=%h c=%b o=%b z=%b want s=0 c=1 o=0 z=1",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_out(lat);
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ripple_cin: got s=%h c=%b o=%b z=%b want s=0 c=1 o=0 z=1",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat;
    send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(lat);
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_overflow: got s=%h c=%b o=%b z=%b want s=80000000 c=0 o=1 z=0",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat;
    send_one(32'd5, 32'd7, 1'b1, 1'b1);
    wait_out(lat);
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_borrow: got s=%h c=%b o=%b z=%b want s=fffffffe c=0 o=0 z=0",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
    send_one(32'd7, 32'd5, 1'b0, 1'b1);
    wait_out(lat);
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'd2, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_no_borrow: got s=%h c=%b o=%b z=%b want s=2 c=1 o=0 z=0",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
    send_one(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    wait_out(lat);
    total++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_overflow: got s=%h c=%b o=%b z=%b want s=7fffffff c=1 o=1 z=0",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    logic [34:0] exp;
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      if (bus.out_valid) begin
        exp = {got * 32'h1111_1112, 1'b0, 1'b0, (got == 0)};
        total++;
        if ({bus.s, bus.cout, bus.ovf, bus.zero} !== exp) begin
          bad++;
          $display("FAIL b2b_result[%0d]: got %h want %h", got,
                   {bus.s, bus.cout, bus.ovf, bus.zero}, exp);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 8) begin
        bus.in_valid = 1'b1;
        bus.a = 32'(c); bus.b = c * 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (first !== 4 || last !== 11 || got !== 8) begin
      bad++;
      $display("FAIL b2b_timing: got first=%0d last=%0d n=%0d want 4 11 8", first, last, got);
    end
  endtask

  task automatic test_stall();
    int issued, exp_id;
    logic [31:0] held;
    issued = 0; exp_id = 0; held = '0;
    for (int c = 0; c < 60 && exp_id < 16; c++) begin
      bus.out_ready = !(c >= 6 && c <= 10);
      bus.in_valid  = (issued < 16);
      bus.a = 32'h100 + 32'(issued); bus.b = 32'(issued * 3); bus.cin = 1'b0; bus.sub = 1'b0;
      #1;
      if (c >= 6 && c <= 10) begin
        if (c == 6) held = bus.s;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01 || bus.s !== held) begin
          bad++;
          $display("FAIL stall_hold[%0d]: got rdy=%b v=%b s=%h want rdy=0 v=1 s=%h",
                   c, bus.in_ready, bus.out_valid, bus.s, held);
        end
      end
      if (bus.in_valid && bus.in_ready) issued++;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (bus.s !== 32'h100 + 32'(exp_id * 4)) begin
          bad++;
          $display("FAIL stall_order[%0d]: got %h want %h", exp_id, bus.s, 32'h100 + 32'(exp_id * 4));
        end
        exp_id++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    total++;
    if (exp_id !== 16) begin
      bad++;
      $display("FAIL stall_count: got %0d want 16", exp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat, stale;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'h20 + 32'(i); bus.b = 32'd1; bus.cin = 1'b0; bus.sub = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.s, bus.zero} !== {1'b0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_flight: got v=%b s=%h z=%b want v=0 s=0 z=1", bus.out_valid, bus.s, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL rst_stale: got %0d valid cycles want 0", stale);
    end
    // Hold a finished result at the output, then reset between clock edges
    bus.out_ready = 1'b0;
    send_one(32'h55, 32'h11, 1'b0, 1'b0);
    wait_out(lat);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.s} !== {1'b1, 32'h66}) begin
      bad++;
      $display("FAIL rst_held_pre: got v=%b s=%h want v=1 s=66", bus.out_valid, bus.s);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_async: got v=%b s=%h c=%b o=%b z=%b want v=0 s=0 c=0 o=0 z=1",
               bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send_one(32'd3, 32'd4, 1'b0, 1'b0);
    wait_out(lat);
    total++;
    if (lat !== 4 || bus.s !== 32'd7) begin
      bad++;
      $display("FAIL rst_recover: got lat=%0d s=%h want lat=4 s=7", lat, bus.s);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [10:0] q1[$];
    logic [10:0] q8[$];
    logic [10:0] exp;
    int n1, n8;
    n1 = 0; n8 = 0;
    for (int c = 0; c < 2600; c++) begin
      if (c < 2560) begin
        sw1.in_valid  = ($urandom_range(0, 9) < 7);
        sw1.out_ready = ($urandom_range(0, 9) < 7);
        sw1.a = 8'($urandom); sw1.b = 8'($urandom);
        sw1.cin = 1'($urandom); sw1.sub = 1'($urandom);
      end else begin
        sw1.in_valid  = 1'b0;
        sw1.out_ready = 1'b1;
      end
      sw8.in_valid = sw1.in_valid; sw8.out_ready = sw1.out_ready;
      sw8.a = sw1.a; sw8.b = sw1.b; sw8.cin = sw1.cin; sw8.sub = sw1.sub;
      #1;
      if (sw1.in_valid && sw1.in_ready) q1.push_back(ref_op(sw1.a, sw1.b, sw1.cin, sw1.sub));
      if (sw8.in_valid && sw8.in_ready) q8.push_back(ref_op(sw8.a, sw8.b, sw8.cin, sw8.sub));
      if (sw1.out_valid && sw1.out_ready) begin
        total++;
        exp = (q1.size() > 0) ? q1.pop_front() : 11'bx;
        if ({sw1.s, sw1.cout, sw1.ovf, sw1.zero} !== exp) begin
          bad++;
          $display("FAIL sweep_s1[%0d]: got %h want %h", n1, {sw1.s, sw1.cout, sw1.ovf, sw1.zero}, exp);
        end
        n1++;
      end
      if (sw8.out_valid && sw8.out_ready) begin
        total++;
        exp = (q8.size() > 0) ? q8.pop_front() : 11'bx;
        if ({sw8.s, sw8.cout, sw8.ovf, sw8.zero} !== exp) begin
          bad++;
          $display("FAIL sweep_s8[%0d]: got %h want %h", n8, {sw8.s, sw8.cout, sw8.ovf, sw8.zero}, exp);
        end
        n8++;
      end
      @(negedge clk);
    end
    total++;
    if (q1.size() != 0 || q8.size() != 0 || n1 < 1000 || n8 < 1000) begin
      bad++;
      $display("FAIL sweep_drain: got left=%0d/%0d done=%0d/%0d want left=0/0 done>=1000",
               q1.size(), q8.size(), n1, n8);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    sw1.in_valid = 1'b0; sw1.out_ready = 1'b1;
    sw1.a = '0; sw1.b = '0; sw1.cin = 1'b0; sw1.sub = 1'b0;
    sw8.in_valid = 1'b0; sw8.out_ready = 1'b1;
    sw8.a = '0; sw8.b = '0; sw8.cin = 1'b0; sw8.sub = 1'b0;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
